crossbar_switch_4x4: RTL and testbench

- Frame-based 4x4 crossbar for 15-bit packets.
- Captures four consecutive input slots, one packet per input port per slot (16 packets per frame), then arbitrates each slot independently.
- Replays the routed slots on the four output ports, one slot per cycle.
- Sits between four ingress links and four egress links; a sequencer drives start and watches ready/req.

---
 rtl/crossbar_switch_4x4_if.sv | 39 +++
 rtl/crossbar_switch_4x4.sv | 171 +++++++++++++++++
 tb/tb_crossbar_switch_4x4.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/crossbar_switch_4x4_if.sv
// ---------------------------------------------------------------------------
// crossbar_switch_4x4_if
//   Bundles the frame handshake and the ingress/egress packet buses of the
//   4x4 frame crossbar.
//
//   start          frame start request from the sequencer
//   iport0..iport3 ingress packets (W bits each)
//   oport0..oport3 egress packets (W bits each)
//   req            egress ports carry a routed slot
//   ready          switch is idle and will accept start
//
//   master : sequencer / link side (drives start and iport*)
//   slave  : crossbar side (drives oport*, req, ready)
// ---------------------------------------------------------------------------
interface crossbar_switch_4x4_if #(
    parameter int W = 15
);
    logic         start;
    logic [W-1:0] iport0;
    logic [W-1:0] iport1;
    logic [W-1:0] iport2;
    logic [W-1:0] iport3;
    logic [W-1:0] oport0;
    logic [W-1:0] oport1;
    logic [W-1:0] oport2;
    logic [W-1:0] oport3;
    logic         req;
    logic         ready;

    modport master (
        output start, iport0, iport1, iport2, iport3,
        input  oport0, oport1, oport2, oport3, req, ready
    );

    modport slave (
        input  start, iport0, iport1, iport2, iport3,
        output oport0, oport1, oport2, oport3, req, ready
    );
endinterface

// File: rtl/crossbar_switch_4x4.sv
// ---------------------------------------------------------------------------
// crossbar_switch_4x4
//   Frame-based 4x4 crossbar. A frame is four consecutive input slots, one
//   packet per ingress port per slot. After capture, every slot is arbitrated
//   independently (lowest-numbered valid input wins each output), and the four
//   routed slots are replayed on the egress ports, one slot per cycle.
//
//   Packet: bit14 valid, bits13:12 destination port, bits11:0 payload.
//   Packets are forwarded unmodified; invalid packets are never routed and
//   losing packets are dropped.
//
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset (aborts any frame in progress)
//     bus  crossbar_switch_4x4_if.slave: start, iport0..3 in;
//          oport0..3, req, ready out
//
//   Timing (slot0 captured on edge E):
//     E..E+3  slots 0..3 captured
//     E+4     routing result registered
//     E+5+k   routed slot k presented on oport* with req=1 for one cycle
//     E+9     oport*/req cleared; a start here begins the next frame
// ---------------------------------------------------------------------------
module crossbar_switch_4x4 #(
    parameter int W     = 15,
    parameter int SLOTS = 4
) (
    input logic                  clk,
    input logic                  rst,
    crossbar_switch_4x4_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE,
        CAP1,
        CAP2,
        CAP3,
        ROUTE,
        OUT0,
        OUT1,
        OUT2,
        OUT3
    } state_t;

    state_t state_q, state_d;

    logic [3:0][W-1:0] iport_vec;
    logic [3:0][W-1:0] slot_q   [SLOTS];
    logic [3:0][W-1:0] slot_d   [SLOTS];
    logic [3:0][W-1:0] routed_q [SLOTS];
    logic [3:0][W-1:0] routed_d [SLOTS];
    logic [3:0][W-1:0] oport_q, oport_d;
    logic              req_q, req_d;
    logic              ready;

    assign iport_vec = {bus.iport3, bus.iport2, bus.iport1, bus.iport0};

    // Fixed-priority arbitration for one output of one slot: the first
    // (lowest-numbered) valid packet addressed to dst wins; no winner gives 0.
    function automatic logic [W-1:0] pick(input logic [3:0][W-1:0] pkts,
                                          input logic [1:0]        dst);
        logic [W-1:0] win;
        logic         found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && pkts[i][W-1] && (pkts[i][W-2 -: 2] == dst)) begin
                win   = pkts[i];
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only matters in IDLE, the rest is a fixed walk
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CAP1;
            CAP1:    state_d = CAP2;
            CAP2:    state_d = CAP3;
            CAP3:    state_d = ROUTE;
            ROUTE:   state_d = OUT0;
            OUT0:    state_d = OUT1;
            OUT1:    state_d = OUT2;
            OUT2:    state_d = OUT3;
            OUT3:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath-control logic. The OUTk states load routed slot k
    // into the egress registers, so slot k is visible in the cycle after OUTk;
    // slot3 is therefore still on the wire during the first IDLE cycle.
    always_comb begin
        slot_d   = slot_q;
        routed_d = routed_q;
        oport_d  = '0;
        req_d    = 1'b0;
        ready    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.start) slot_d[0] = iport_vec;
            end
            CAP1: slot_d[1] = iport_vec;
            CAP2: slot_d[2] = iport_vec;
            CAP3: slot_d[3] = iport_vec;
            ROUTE: begin
                for (int s = 0; s < SLOTS; s++) begin
                    for (int j = 0; j < 4; j++) begin
                        routed_d[s][j] = pick(slot_q[s], 2'(j));
                    end
                end
            end
            OUT0: begin
                oport_d = routed_q[0];
                req_d   = 1'b1;
            end
            OUT1: begin
                oport_d = routed_q[1];
                req_d   = 1'b1;
            end
            OUT2: begin
                oport_d = routed_q[2];
                req_d   = 1'b1;
            end
            OUT3: begin
                oport_d = routed_q[3];
                req_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Slot buffers, routed buffers and registered egress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SLOTS; s++) begin
                slot_q[s]   <= '0;
                routed_q[s] <= '0;
            end
            oport_q <= '0;
            req_q   <= 1'b0;
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                slot_q[s]   <= slot_d[s];
                routed_q[s] <= routed_d[s];
            end
            oport_q <= oport_d;
            req_q   <= req_d;
        end
    end

    assign bus.oport0 = oport_q[0];
    assign bus.oport1 = oport_q[1];
    assign bus.oport2 = oport_q[2];
    assign bus.oport3 = oport_q[3];
    assign bus.req    = req_q;
    assign bus.ready  = ready;

endmodule

// File: tb/tb_crossbar_switch_4x4.sv
// ---------------------------------------------------------------------------
// tb_crossbar_switch_4x4
//   Directed frames with hand-computed routing results. Each frame pushes its
//   four expected egress slots into a queue; a negedge monitor pops one entry
//   per req cycle and compares all four ports, and requires oport*=0 whenever
//   req is low. The stimulus process checks ready/req timing per edge.
// ---------------------------------------------------------------------------
module tb_crossbar_switch_4x4;
    localparam int W = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    crossbar_switch_4x4_if #(.W(W)) bus ();

    crossbar_switch_4x4 #(.W(W), .SLOTS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [4*W-1:0]    exp_q [$];
    logic [4*W-1:0]    mon_exp;
    logic [3:0][W-1:0] stim [4];
    logic [3:0][W-1:0] expd [4];

    function automatic logic [3:0][W-1:0] mk(input logic [W-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [3:0][W-1:0] v);
        bus.iport0 = v[0];
        bus.iport1 = v[1];
        bus.iport2 = v[2];
        bus.iport3 = v[3];
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: req=1 with no expected slot at %0t", $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("slot_oport0", bus.oport0, mon_exp[0*W +: W]);
                    chk("slot_oport1", bus.oport1, mon_exp[1*W +: W]);
                    chk("slot_oport2", bus.oport2, mon_exp[2*W +: W]);
                    chk("slot_oport3", bus.oport3, mon_exp[3*W +: W]);
                end
            end else begin
                chk("idle_oport0", bus.oport0, '0);
                chk("idle_oport1", bus.oport1, '0);
                chk("idle_oport2", bus.oport2, '0);
                chk("idle_oport3", bus.oport3, '0);
            end
        end
    end

    // Issues one frame from stim[], starting at a point after the clock's
    // falling edge while the DUT is idle. Edge m=0 captures slot0.
    // pat=1 drives start as 1,0,1,0 over the capture cycles and also pulses
    // start during ROUTE; none of those extra pulses may restart the frame.
    task automatic drive_frame(input bit pat);
        for (int k = 0; k < 4; k++) exp_q.push_back(expd[k]);
        set_in(stim[0]);
        bus.start = 1'b1;
        for (int m = 0; m < 9; m++) begin
            @(posedge clk);
            #1;
            if (m < 3) begin
                set_in(stim[m+1]);
                bus.start = pat && (m == 1);
            end else begin
                set_in(mk(15'h7FFF, 15'h4ABC, 15'h5DEF, 15'h6123));
                bus.start = pat && (m == 3);
            end
            @(negedge clk);
            chk($sformatf("ready_e%0d", m), 15'(bus.ready), 15'(m >= 8));
            chk($sformatf("req_e%0d", m), 15'(bus.req), 15'((m >= 5) && (m <= 8)));
        end
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        set_in('0);

        // Power-on reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 15'(bus.ready), 15'd1);
        chk("rst_req", 15'(bus.req), 15'd0);
        chk("rst_oport0", bus.oport0, '0);
        chk("rst_oport3", bus.oport3, '0);
        rst = 1'b0;
        @(negedge clk);

        // Frame 1: permutation, contention, invalid, mixed; start 1,0,1,0
        stim[0] = mk(15'h7011, 15'h6022, 15'h5033, 15'h4044);
        expd[0] = mk(15'h4044, 15'h5033, 15'h6022, 15'h7011);
        stim[1] = mk(15'h6001, 15'h6002, 15'h6003, 15'h6004);
        expd[1] = mk(15'h0000, 15'h0000, 15'h6001, 15'h0000);
        stim[2] = mk(15'h3ABC, 15'h0000, 15'h1123, 15'h2FFF);
        expd[2] = mk(15'h0000, 15'h0000, 15'h0000, 15'h0000);
        stim[3] = mk(15'h50AA, 15'h3FFF, 15'h7055, 15'h5BBB);
        expd[3] = mk(15'h0000, 15'h50AA, 15'h0000, 15'h7055);
        drive_frame(1'b1);

        // Frame 2: back-to-back, start in the first IDLE cycle after OUT3
        stim[0] = mk(15'h4001, 15'h4002, 15'h7003, 15'h6004);
        expd[0] = mk(15'h4001, 15'h0000, 15'h6004, 15'h7003);
        stim[1] = mk(15'h5111, 15'h4222, 15'h7333, 15'h6444);
        expd[1] = mk(15'h4222, 15'h5111, 15'h6444, 15'h7333);
        stim[2] = mk(15'h0000, 15'h0000, 15'h0000, 15'h0000);
        expd[2] = mk(15'h0000, 15'h0000, 15'h0000, 15'h0000);
        stim[3] = mk(15'h7FFF, 15'h7000, 15'h3FFF, 15'h4ABC);
        expd[3] = mk(15'h4ABC, 15'h0000, 15'h0000, 15'h7FFF);
        drive_frame(1'b0);

        // Edge E+9 of frame 2 with no start: outputs clear, switch stays idle
        @(posedge clk);
        @(negedge clk);
        chk("end_ready", 15'(bus.ready), 15'd1);
        chk("end_req", 15'(bus.req), 15'd0);

        // Aborted frame: reset asserted in the middle of CAP2
        set_in(mk(15'h4111, 15'h5222, 15'h6333, 15'h7444));
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        set_in(mk(15'h7555, 15'h6666, 15'h5777, 15'h4888));
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("cap2_ready", 15'(bus.ready), 15'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_ready", 15'(bus.ready), 15'd1);
        chk("async_req", 15'(bus.req), 15'd0);
        chk("async_oport1", bus.oport1, '0);
        chk("async_oport2", bus.oport2, '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_in('0);
        repeat (10) @(negedge clk);

        // Frame 4 after reset: must route only its own data
        stim[0] = mk(15'h0123, 15'h1456, 15'h2789, 15'h3ABC);
        expd[0] = mk(15'h0000, 15'h0000, 15'h0000, 15'h0000);
        stim[1] = mk(15'h4101, 15'h5102, 15'h6103, 15'h7104);
        expd[1] = mk(15'h4101, 15'h5102, 15'h6103, 15'h7104);
        stim[2] = mk(15'h0000, 15'h0000, 15'h0000, 15'h6AAA);
        expd[2] = mk(15'h0000, 15'h0000, 15'h6AAA, 15'h0000);
        stim[3] = mk(15'h0000, 15'h0000, 15'h0000, 15'h0000);
        expd[3] = mk(15'h0000, 15'h0000, 15'h0000, 15'h0000);
        drive_frame(1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 15'(exp_q.size()), 15'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a stuck simulation
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
